ps2_joy: RTL
============

// Module: ps2_joy
// PURPOSE
//  PS/2 keyboard receiver and scan-code decoder that drives the NES joypad
//  button bytes joy1/joy2 consumed by the ppu joystick ports ($4016/$4017).
//  Receives device-to-host frames on PS2_CLK/PS2_DAT, decodes set-2 make,
//  break (F0) and extended (E0) codes, and holds one pressed-flag per button.
//  Runs in the clock_25 domain.
// PARAMETERS
//  TIMEOUT  5000  clocks with no PS/2 falling edge before a partial frame is aborted (200 us @ 25 MHz)
// PORTS
//  clock      in   1  system clock (clock_25)
//  reset_n    in   1  asynchronous active-low reset
//  ps2_clk    in   1  PS/2 clock line (asynchronous)
//  ps2_dat    in   1  PS/2 data line (asynchronous)
//  joy1       out  8  player-1 buttons, 1 = pressed: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//  joy2       out  8  player-2 buttons, same bit order
//  rx_data    out  8  last received byte
//  rx_valid   out  1  one-cycle strobe, rx_data is new
//  rx_err     out  1  one-cycle strobe: parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset: joy1=joy2=rx_data=8'h00, rx_valid=rx_err=0, receiver IDLE, E0/F0 flags clear, sync flops = 1.
//  Sync: ps2_clk and ps2_dat each pass through 3 flops; fall = (clk_s[2:1]==2'b10); data sampled from dat_s[2] on fall.
//  Receiver FSM (bit counter 0..10):
//   IDLE: on fall, sampled 0 -> RECV, cnt=1; sampled 1 -> ignored, stay IDLE, no error.
//   RECV: on fall, cnt 1..8 shift data LSB first, cnt 9 = parity, cnt 10 = stop.
//   After stop: parity must make the 9 bits odd and stop must be 1; pass -> rx_data, rx_valid=1
//    in the next cycle; fail -> rx_err=1 in the next cycle, rx_data unchanged. Return to IDLE.
//   Timeout counter ($clog2(TIMEOUT+1) bits) clears on every fall and counts in RECV;
//    reaching TIMEOUT -> rx_err=1 for one cycle, IDLE, cnt=0. Never counts in IDLE.
//  Decoder (acts on the rx_valid cycle; joy bits change on the following cycle, 2 cycles after the stop edge):
//   byte E0 -> ext=1; byte F0 -> brk=1; byte E1 -> ignored, flags kept.
//   any other byte: looked up with ext; if mapped, target bit <= ~brk; then ext=brk=0.
//   Unmapped codes only clear ext/brk. rx_err clears ext and brk.
//   Map (player 1): 22 X=A, 1A Z=B, 29 Space=Select, 5A Enter=Start,
//    E0 75 Up, E0 72 Down, E0 6B Left, E0 74 Right. Non-E0 75/72/6B/74 (keypad) unmapped.
//   Opposite directions may both be set; no SOCD filtering. Typematic repeats rewrite the same value.
//  Reset mid-frame discards the partial frame and all button state.
// CONFIGURATION
//  PS2_JOY2_EN defined: player-2 map active: 1D W=Up, 1B S=Down, 1C A=Left, 23 D=Right,
//   42 K=A, 3B J=B, 2C T=Select, 35 Y=Start (no E0). Undefined: joy2 tied 8'h00,
//   these codes unmapped.
// STRUCTURE
//  ps2_joy_pkg: scan-code localparams (SC_E0, SC_F0, SC_E1, per-key codes), button index
//   constants BTN_A..BTN_RIGHT, receiver state encoding.
//  Sub-module ps2_rx: synchroniser, edge detect, frame FSM, timeout -> rx_data/rx_valid/rx_err.
//  ps2_joy: instantiates ps2_rx, holds ext/brk flags, decode table and joy registers.
// TESTING
//  Frame 22 (parity 1) -> rx_valid, rx_data=22, joy1=01; then F0,22 -> joy1=00.
//  E0,75 -> joy1=10; E0,F0,75 -> joy1=00; plain 75 -> joy1 unchanged, rx_valid only.
//  Frame 5A with parity 0 -> rx_err pulse, joy1 unchanged; good 5A -> joy1=08.
//  5 bits then stall 5001 clocks -> one rx_err, FSM IDLE; next frame 1A -> joy1=02.
//  joy1=09, reset_n low after 6 bits -> joy1=joy2=00; after release frame 29 -> joy1=04.
//  PS2_JOY2_EN: 1D -> joy2=10, joy1 unchanged; undefined: 1D -> joy2 stays 00.

Source files
------------

// File: rtl/ps2_joy_pkg.sv
// ps2_joy_pkg: scan codes, button indices, receiver states and key map for ps2_joy.
// The player-2 key map is compiled in only when PS2_JOY2_EN is defined.
package ps2_joy_pkg;
   localparam logic [7:0] SC_E0 = 8'hE0, SC_F0 = 8'hF0, SC_E1 = 8'hE1;
   localparam logic [7:0] SC_X = 8'h22, SC_Z = 8'h1A, SC_SPACE = 8'h29, SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_W = 8'h1D, SC_S = 8'h1B, SC_A = 8'h1C, SC_D = 8'h23;
   localparam logic [7:0] SC_K = 8'h42, SC_J = 8'h3B, SC_T = 8'h2C, SC_Y = 8'h35;
   localparam logic [2:0] BTN_A = 3'd0, BTN_B = 3'd1, BTN_SELECT = 3'd2, BTN_START = 3'd3;
   localparam logic [2:0] BTN_UP = 3'd4, BTN_DOWN = 3'd5, BTN_LEFT = 3'd6, BTN_RIGHT = 3'd7;
   typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
   typedef struct packed {
      logic       hit;
      logic       p2;
      logic [2:0] idx;
   } key_t;
   // {hit, p2} prefix: 2'b10 = player 1, 2'b11 = player 2; prefix codes never hit
   function automatic key_t key_map(input logic ext, input logic [7:0] code);
      key_t k;
      k = '0;
      case ({ext, code})
         {1'b0, SC_X}:     k = {2'b10, BTN_A};
         {1'b0, SC_Z}:     k = {2'b10, BTN_B};
         {1'b0, SC_SPACE}: k = {2'b10, BTN_SELECT};
         {1'b0, SC_ENTER}: k = {2'b10, BTN_START};
         {1'b1, SC_UP}:    k = {2'b10, BTN_UP};
         {1'b1, SC_DOWN}:  k = {2'b10, BTN_DOWN};
         {1'b1, SC_LEFT}:  k = {2'b10, BTN_LEFT};
         {1'b1, SC_RIGHT}: k = {2'b10, BTN_RIGHT};
`ifdef PS2_JOY2_EN
         {1'b0, SC_W}:     k = {2'b11, BTN_UP};
         {1'b0, SC_S}:     k = {2'b11, BTN_DOWN};
         {1'b0, SC_A}:     k = {2'b11, BTN_LEFT};
         {1'b0, SC_D}:     k = {2'b11, BTN_RIGHT};
         {1'b0, SC_K}:     k = {2'b11, BTN_A};
         {1'b0, SC_J}:     k = {2'b11, BTN_B};
         {1'b0, SC_T}:     k = {2'b11, BTN_SELECT};
         {1'b0, SC_Y}:     k = {2'b11, BTN_START};
`endif
         default:          k = '0;
      endcase
      return k;
   endfunction
endpackage

// File: rtl/ps2_joy_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with synchroniser and inactivity timeout.
// Ports: clock, reset_n (async active-low), ps2_clk/ps2_dat (async lines),
//        rx_data (last good byte), rx_valid (new byte strobe), rx_err (parity/stop/timeout strobe).
module ps2_rx #(
   parameter int TIMEOUT = 5000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err
);
   import ps2_joy_pkg::*;
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [2:0] clk_s, dat_s;
   logic fall, ok, bad;
   rx_state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [8:0] sh, sh_n;
   logic [TW-1:0] tmo, tmo_n;
   assign fall = clk_s[2:1] == 2'b10;
   // sh collects 8 data bits then parity, LSB first; tmo stays zero in IDLE
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      sh_n = sh;
      tmo_n = '0;
      ok = 1'b0;
      bad = 1'b0;
      if (state == RX_IDLE) begin
         if (fall && !dat_s[2]) begin
            state_n = RX_RECV;
            cnt_n = 4'd1;
         end
      end else if (fall) begin
         if (cnt == 4'd10) begin
            state_n = RX_IDLE;
            cnt_n = '0;
            ok = dat_s[2] & ^sh;
            bad = ~ok;
         end else begin
            sh_n = {dat_s[2], sh[8:1]};
            cnt_n = cnt + 4'd1;
         end
      end else if (tmo == TW'(TIMEOUT - 1)) begin
         state_n = RX_IDLE;
         cnt_n = '0;
         bad = 1'b1;
      end else begin
         tmo_n = tmo + 1'b1;
      end
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_s <= '1;
         dat_s <= '1;
         state <= RX_IDLE;
         cnt <= '0;
         sh <= '0;
         tmo <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         rx_err <= 1'b0;
      end else begin
         clk_s <= {clk_s[1:0], ps2_clk};
         dat_s <= {dat_s[1:0], ps2_dat};
         state <= state_n;
         cnt <= cnt_n;
         sh <= sh_n;
         tmo <= tmo_n;
         rx_valid <= ok;
         rx_err <= bad;
         if (ok) rx_data <= sh[7:0];
      end
   end
endmodule

// File: rtl/ps2_joy.sv
// ps2_joy: PS/2 keyboard to NES joypad button bytes (set-2 make/break/extended decode).
// Ports: clock, reset_n (async active-low), ps2_clk/ps2_dat (async PS/2 lines),
//        joy1/joy2 (1 = pressed: A,B,Select,Start,Up,Down,Left,Right from bit 0),
//        rx_data/rx_valid/rx_err (receiver byte, new-byte strobe, error strobe).
// Define PS2_JOY2_EN to enable the player-2 key map; otherwise joy2 is tied to zero.
module ps2_joy #(
   parameter int TIMEOUT = 5000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] joy1,
   output logic [7:0] joy2,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err
);
   import ps2_joy_pkg::*;
   logic ext, brk;
   key_t key;
   ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
      .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
   );
   // prefix bytes never hit, so key.hit alone qualifies a button update
   assign key = key_map(ext, rx_data);
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ext <= 1'b0;
         brk <= 1'b0;
         joy1 <= '0;
      end else if (rx_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (rx_valid) begin
         if (rx_data == SC_E0) ext <= 1'b1;
         else if (rx_data == SC_F0) brk <= 1'b1;
         else if (rx_data != SC_E1) begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (key.hit && !key.p2) joy1[key.idx] <= ~brk;
         end
      end
   end
`ifdef PS2_JOY2_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) joy2 <= '0;
      else if (rx_valid && key.hit && key.p2) joy2[key.idx] <= ~brk;
   end
`else
   assign joy2 = 8'h00;
`endif
endmodule
